// File: rtl/pipeline_wb_regfile_if.sv
// Writeback stage bus: MEM->W pipeline inputs, W-stage controls, decode read ports
// and the stage's observable outputs.
//   master : upstream/driver side (MEM stage, hazard unit, decode)
//   slave  : the writeback/register-file block
interface pipeline_wb_regfile_if #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned INSTRET_W = 32
);
    logic                 valid_m_i;
    logic [XLEN-1:0]      mem_read_data_m_i;
    logic [XLEN-1:0]      alu_result_m_i;
    logic [XLEN-1:0]      extended_imm_m_i;
    logic [XLEN-1:0]      pc_plus_m_i;
    logic                 reg_write_en_m_i;
    logic [4:0]           rd_idx_m_i;
    logic [3:0]           result_src_m_i;
    logic                 stall_w_i;
    logic                 flush_w_i;
    logic [4:0]           rs1_idx_d_i;
    logic [4:0]           rs2_idx_d_i;
    logic [XLEN-1:0]      rs1_data_d_o;
    logic [XLEN-1:0]      rs2_data_d_o;
    logic [XLEN-1:0]      result_w_o;
    logic [4:0]           rd_idx_w_o;
    logic                 reg_write_en_w_o;
    logic [INSTRET_W-1:0] instret_o;
    logic                 illegal_src_o;

    modport master (
        output valid_m_i, mem_read_data_m_i, alu_result_m_i, extended_imm_m_i, pc_plus_m_i,
        output reg_write_en_m_i, rd_idx_m_i, result_src_m_i, stall_w_i, flush_w_i,
        output rs1_idx_d_i, rs2_idx_d_i,
        input  rs1_data_d_o, rs2_data_d_o, result_w_o, rd_idx_w_o, reg_write_en_w_o,
        input  instret_o, illegal_src_o
    );

    modport slave (
        input  valid_m_i, mem_read_data_m_i, alu_result_m_i, extended_imm_m_i, pc_plus_m_i,
        input  reg_write_en_m_i, rd_idx_m_i, result_src_m_i, stall_w_i, flush_w_i,
        input  rs1_idx_d_i, rs2_idx_d_i,
        output rs1_data_d_o, rs2_data_d_o, result_w_o, rd_idx_w_o, reg_write_en_w_o,
        output instret_o, illegal_src_o
    );
endinterface

// File: rtl/pipeline_wb_regfile.sv
// Writeback stage with integer register file.
// Registers the MEM-stage outputs (M->W register), selects the writeback result by
// result_src, commits it to the register file and serves two decode read ports with
// same-cycle write bypass. Counts retired instructions and flags undefined result_src.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : pipeline_wb_regfile_if.slave (MEM inputs, stall/flush, read ports, outputs)
module pipeline_wb_regfile #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned REG_NUM   = 32,
    parameter int unsigned INSTRET_W = 32
) (
    input logic                 clk,
    input logic                 reset,
    pipeline_wb_regfile_if.slave bus
);
    // M->W pipeline register
    logic                 r_valid;
    logic                 r_we;
    logic [4:0]           r_rd;
    logic [3:0]           r_src;
    logic [XLEN-1:0]      r_alu;
    logic [XLEN-1:0]      r_mem;
    logic [XLEN-1:0]      r_imm;
    logic [XLEN-1:0]      r_pc;

    logic [XLEN-1:0]      r_regs [REG_NUM];
    logic [INSTRET_W-1:0] r_instret;
    logic                 r_illegal;

    logic                 w_src_legal;
    logic [XLEN-1:0]      w_result;
    logic                 w_we_eff;
    logic                 w_retire;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_we    <= 1'b0;
            r_rd    <= '0;
            r_src   <= '0;
            r_alu   <= '0;
            r_mem   <= '0;
            r_imm   <= '0;
            r_pc    <= '0;
        end else if (bus.flush_w_i) begin
            // Bubble; flush overrides a simultaneous stall
            r_valid <= 1'b0;
            r_we    <= 1'b0;
            r_rd    <= '0;
            r_src   <= '0;
            r_alu   <= '0;
            r_mem   <= '0;
            r_imm   <= '0;
            r_pc    <= '0;
        end else if (!bus.stall_w_i) begin
            r_valid <= bus.valid_m_i;
            r_we    <= bus.reg_write_en_m_i;
            r_rd    <= bus.rd_idx_m_i;
            r_src   <= bus.result_src_m_i;
            r_alu   <= bus.alu_result_m_i;
            r_mem   <= bus.mem_read_data_m_i;
            r_imm   <= bus.extended_imm_m_i;
            r_pc    <= bus.pc_plus_m_i;
        end
    end

    // Only codes 0..3 are defined
    assign w_src_legal = (r_src[3:2] == 2'b00);

    always_comb begin
        w_result = '0;
        case (r_src)
            4'd0:    w_result = r_alu;
            4'd1:    w_result = r_mem;
            4'd2:    w_result = r_imm;
            4'd3:    w_result = r_pc;
            default: w_result = '0;
        endcase
    end

    // A stalled instruction neither writes nor retires; it does so once on release
    assign w_we_eff = r_valid & r_we & (r_rd != 5'd0) & w_src_legal & ~bus.stall_w_i;
    assign w_retire = r_valid & w_src_legal & ~bus.stall_w_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(REG_NUM); i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_we_eff) begin
            r_regs[r_rd] <= w_result;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instret <= '0;
            r_illegal <= 1'b0;
        end else begin
            if (w_retire) begin
                r_instret <= r_instret + INSTRET_W'(1);
            end
            if (r_valid && !w_src_legal) begin
                r_illegal <= 1'b1;
            end
        end
    end

    // Read ports: x0 reads zero, then bypass the write happening this cycle
    assign bus.rs1_data_d_o = (bus.rs1_idx_d_i == 5'd0) ? '0 :
                              (w_we_eff && bus.rs1_idx_d_i == r_rd) ? w_result :
                              r_regs[bus.rs1_idx_d_i];
    assign bus.rs2_data_d_o = (bus.rs2_idx_d_i == 5'd0) ? '0 :
                              (w_we_eff && bus.rs2_idx_d_i == r_rd) ? w_result :
                              r_regs[bus.rs2_idx_d_i];

    assign bus.result_w_o       = w_result;
    assign bus.rd_idx_w_o       = r_rd;
    assign bus.reg_write_en_w_o = w_we_eff;
    assign bus.instret_o        = r_instret;
    assign bus.illegal_src_o    = r_illegal;
endmodule

// File: tb/tb_pipeline_wb_regfile.sv
// Bench for pipeline_wb_regfile: directed scenarios plus a randomized run checked
// against an instruction-level reference model of the writeback stage.
module tb_pipeline_wb_regfile;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipeline_wb_regfile_if #(.XLEN(32), .INSTRET_W(32)) bus ();
    pipeline_wb_regfile_if #(.XLEN(32), .INSTRET_W(4))  sbus ();

    pipeline_wb_regfile #(.XLEN(32), .REG_NUM(32), .INSTRET_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Narrow counter instance to exercise the instret wrap
    pipeline_wb_regfile #(.XLEN(32), .REG_NUM(32), .INSTRET_W(4)) dut_small (
        .clk   (clk),
        .reset (reset),
        .bus   (sbus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: architectural registers plus the one instruction sitting in W
    logic [31:0] m_regs [32];
    logic        m_wv;
    logic        m_wwe;
    logic [4:0]  m_wrd;
    logic [3:0]  m_wsrc;
    logic [31:0] m_wval;
    logic [31:0] m_instret;
    logic        m_ill;

    function automatic logic m_legal();
        return m_wsrc < 4'd4;
    endfunction

    function automatic logic [31:0] m_result();
        return m_legal() ? m_wval : 32'd0;
    endfunction

    function automatic logic m_we();
        return m_wv && m_wwe && (m_wrd != 5'd0) && m_legal() && !bus.stall_w_i;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (m_we() && idx == m_wrd) return m_result();
        return m_regs[idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_wv = 0; m_wwe = 0; m_wrd = 0; m_wsrc = 0; m_wval = 0;
        m_instret = 0; m_ill = 0;
    endtask

    task automatic model_edge();
        logic [31:0] vals [4];
        if (m_we()) m_regs[m_wrd] = m_result();
        if (m_wv && !bus.stall_w_i && m_legal()) m_instret = m_instret + 1;
        if (m_wv && !m_legal()) m_ill = 1'b1;
        if (bus.flush_w_i) begin
            m_wv = 0; m_wwe = 0;
        end else if (!bus.stall_w_i) begin
            vals[0] = bus.alu_result_m_i;
            vals[1] = bus.mem_read_data_m_i;
            vals[2] = bus.extended_imm_m_i;
            vals[3] = bus.pc_plus_m_i;
            m_wv   = bus.valid_m_i;
            m_wwe  = bus.reg_write_en_m_i;
            m_wrd  = bus.rd_idx_m_i;
            m_wsrc = bus.result_src_m_i;
            m_wval = (bus.result_src_m_i < 4'd4) ? vals[bus.result_src_m_i[1:0]] : 32'd0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else model_edge();
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic [4:0] rd,
                         input logic [3:0] src, input logic [31:0] alu, input logic [31:0] mem,
                         input logic [31:0] imm, input logic [31:0] pc);
        bus.valid_m_i = v;          bus.reg_write_en_m_i  = we;
        bus.rd_idx_m_i = rd;        bus.result_src_m_i    = src;
        bus.alu_result_m_i = alu;   bus.mem_read_data_m_i = mem;
        bus.extended_imm_m_i = imm; bus.pc_plus_m_i       = pc;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        bus.stall_w_i = 0; bus.flush_w_i = 0;
        bus.rs1_idx_d_i = 5'd5; bus.rs2_idx_d_i = 5'd31;
        sbus.valid_m_i = 0; sbus.reg_write_en_m_i = 0; sbus.rd_idx_m_i = 0;
        sbus.result_src_m_i = 0; sbus.alu_result_m_i = 0; sbus.mem_read_data_m_i = 0;
        sbus.extended_imm_m_i = 0; sbus.pc_plus_m_i = 0; sbus.stall_w_i = 0;
        sbus.flush_w_i = 0; sbus.rs1_idx_d_i = 0; sbus.rs2_idx_d_i = 0;
        model_reset();
        #12;
        n_cmp++;
        if (bus.result_w_o !== 32'd0 || bus.rd_idx_w_o !== 5'd0 || bus.reg_write_en_w_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_w: result=%h rd=%0d we=%b expected 0/0/0",
                     bus.result_w_o, bus.rd_idx_w_o, bus.reg_write_en_w_o);
        end
        n_cmp++;
        if (bus.instret_o !== 32'd0 || bus.illegal_src_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_cnt: instret=%h illegal=%b expected 0/0",
                     bus.instret_o, bus.illegal_src_o);
        end
        n_cmp++;
        if (bus.rs1_data_d_o !== 32'd0 || bus.rs2_data_d_o !== 32'd0) begin
            n_err++;
            $display("FAIL reset_regs: rs1=%h rs2=%h expected 0/0", bus.rs1_data_d_o, bus.rs2_data_d_o);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_alu();
        drive(1, 1, 5'd5, 4'd0, 32'h1234_5678, 32'h1, 32'h2, 32'h3);
        tick();
        idle();
        n_cmp++;
        if (bus.reg_write_en_w_o !== 1'b1 || bus.result_w_o !== 32'h1234_5678 || bus.rd_idx_w_o !== 5'd5) begin
            n_err++;
            $display("FAIL alu_w: we=%b result=%h rd=%0d expected 1/12345678/5",
                     bus.reg_write_en_w_o, bus.result_w_o, bus.rd_idx_w_o);
        end
        tick();
        bus.rs1_idx_d_i = 5'd5;
        #1;
        n_cmp++;
        if (bus.rs1_data_d_o !== 32'h1234_5678 || bus.instret_o !== 32'd1) begin
            n_err++;
            $display("FAIL alu_commit: reg5=%h instret=%0d expected 12345678/1",
                     bus.rs1_data_d_o, bus.instret_o);
        end
    endtask

    task automatic test_bypass();
        drive(1, 1, 5'd6, 4'd1, 32'h5, 32'hAAFF_5678, 32'h7, 32'h9);
        tick();
        idle();
        bus.rs1_idx_d_i = 5'd6; bus.rs2_idx_d_i = 5'd6;
        #1;
        n_cmp++;
        if (bus.rs1_data_d_o !== 32'hAAFF_5678 || bus.rs2_data_d_o !== 32'hAAFF_5678) begin
            n_err++;
            $display("FAIL bypass: rs1=%h rs2=%h expected aaff5678 on both",
                     bus.rs1_data_d_o, bus.rs2_data_d_o);
        end
        tick();
        n_cmp++;
        if (bus.rs1_data_d_o !== 32'hAAFF_5678 || bus.instret_o !== 32'd2) begin
            n_err++;
            $display("FAIL load_commit: reg6=%h instret=%0d expected aaff5678/2",
                     bus.rs1_data_d_o, bus.instret_o);
        end
    endtask

    task automatic test_rd_zero();
        drive(1, 1, 5'd0, 4'd0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0);
        tick();
        idle();
        bus.rs1_idx_d_i = 5'd0;
        #1;
        n_cmp++;
        if (bus.reg_write_en_w_o !== 1'b0 || bus.rs1_data_d_o !== 32'd0) begin
            n_err++;
            $display("FAIL rd_zero: we=%b x0=%h expected 0/0", bus.reg_write_en_w_o, bus.rs1_data_d_o);
        end
        tick();
        n_cmp++;
        if (bus.instret_o !== 32'd3 || bus.rs1_data_d_o !== 32'd0) begin
            n_err++;
            $display("FAIL rd_zero_retire: instret=%0d x0=%h expected 3/0", bus.instret_o, bus.rs1_data_d_o);
        end
    endtask

    task automatic test_stall();
        drive(1, 1, 5'd7, 4'd3, 32'h55, 32'h66, 32'h77, 32'h104);
        tick();
        idle();
        bus.stall_w_i = 1'b1;
        bus.rs1_idx_d_i = 5'd7;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (bus.reg_write_en_w_o !== 1'b0 || bus.rs1_data_d_o !== 32'd0 || bus.instret_o !== 32'd3) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: we=%b reg7=%h instret=%0d expected 0/0/3",
                         i, bus.reg_write_en_w_o, bus.rs1_data_d_o, bus.instret_o);
            end
            tick();
        end
        bus.stall_w_i = 1'b0;
        #1;
        n_cmp++;
        if (bus.reg_write_en_w_o !== 1'b1 || bus.rs1_data_d_o !== 32'h104) begin
            n_err++;
            $display("FAIL stall_release: we=%b rs1=%h expected 1/104", bus.reg_write_en_w_o, bus.rs1_data_d_o);
        end
        tick();
        tick();
        n_cmp++;
        if (bus.rs1_data_d_o !== 32'h104 || bus.instret_o !== 32'd4) begin
            n_err++;
            $display("FAIL stall_commit_once: reg7=%h instret=%0d expected 104/4",
                     bus.rs1_data_d_o, bus.instret_o);
        end
    endtask

    task automatic test_flush();
        drive(1, 1, 5'd8, 4'd0, 32'h88, 32'h0, 32'h0, 32'h0);
        bus.flush_w_i = 1'b1;
        tick();
        bus.flush_w_i = 1'b0;
        idle();
        tick();
        bus.rs1_idx_d_i = 5'd8;
        #1;
        n_cmp++;
        if (bus.rs1_data_d_o !== 32'd0 || bus.instret_o !== 32'd4) begin
            n_err++;
            $display("FAIL flush: reg8=%h instret=%0d expected 0/4", bus.rs1_data_d_o, bus.instret_o);
        end
        drive(1, 1, 5'd9, 4'd0, 32'h99, 32'h0, 32'h0, 32'h0);
        tick();
        drive(1, 1, 5'd10, 4'd0, 32'hA0, 32'h0, 32'h0, 32'h0);
        bus.flush_w_i = 1'b1; bus.stall_w_i = 1'b1;
        tick();
        bus.flush_w_i = 1'b0; bus.stall_w_i = 1'b0;
        idle();
        tick();
        bus.rs1_idx_d_i = 5'd9; bus.rs2_idx_d_i = 5'd10;
        #1;
        n_cmp++;
        if (bus.rs1_data_d_o !== 32'd0 || bus.rs2_data_d_o !== 32'd0 || bus.instret_o !== 32'd4) begin
            n_err++;
            $display("FAIL flush_stall: reg9=%h reg10=%h instret=%0d expected 0/0/4",
                     bus.rs1_data_d_o, bus.rs2_data_d_o, bus.instret_o);
        end
    endtask

    task automatic test_illegal();
        drive(1, 1, 5'd11, 4'd9, 32'h11, 32'h12, 32'h13, 32'h14);
        tick();
        idle();
        bus.rs1_idx_d_i = 5'd11;
        #1;
        n_cmp++;
        if (bus.result_w_o !== 32'd0 || bus.reg_write_en_w_o !== 1'b0 || bus.illegal_src_o !== 1'b0) begin
            n_err++;
            $display("FAIL illegal_w: result=%h we=%b illegal=%b expected 0/0/0",
                     bus.result_w_o, bus.reg_write_en_w_o, bus.illegal_src_o);
        end
        tick();
        tick();
        tick();
        n_cmp++;
        if (bus.illegal_src_o !== 1'b1 || bus.instret_o !== 32'd4 || bus.rs1_data_d_o !== 32'd0) begin
            n_err++;
            $display("FAIL illegal_sticky: illegal=%b instret=%0d reg11=%h expected 1/4/0",
                     bus.illegal_src_o, bus.instret_o, bus.rs1_data_d_o);
        end
    endtask

    task automatic test_reset_midop();
        drive(1, 1, 5'd12, 4'd0, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0);
        tick();
        idle();
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (bus.reg_write_en_w_o !== 1'b0 || bus.illegal_src_o !== 1'b0 || bus.instret_o !== 32'd0) begin
            n_err++;
            $display("FAIL reset_async: we=%b illegal=%b instret=%0d expected 0/0/0",
                     bus.reg_write_en_w_o, bus.illegal_src_o, bus.instret_o);
        end
        tick();
        @(negedge clk);
        reset = 1'b0;
        bus.rs1_idx_d_i = 5'd12; bus.rs2_idx_d_i = 5'd5;
        #1;
        n_cmp++;
        if (bus.rs1_data_d_o !== 32'd0 || bus.rs2_data_d_o !== 32'd0) begin
            n_err++;
            $display("FAIL reset_midop: reg12=%h reg5=%h expected 0/0", bus.rs1_data_d_o, bus.rs2_data_d_o);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] exp_cnt;
        pulse_reset();
        sbus.valid_m_i = 1; sbus.reg_write_en_m_i = 1; sbus.rd_idx_m_i = 5'd1;
        for (int i = 0; i < 16; i++) begin
            sbus.alu_result_m_i = 32'(i);
            tick();
        end
        sbus.valid_m_i = 0;
        n_cmp++;
        if (sbus.instret_o !== 4'd15) begin
            n_err++;
            $display("FAIL wrap_max: instret=%0d expected 15", sbus.instret_o);
        end
        tick();
        n_cmp++;
        if (sbus.instret_o !== 4'd0) begin
            n_err++;
            $display("FAIL wrap_zero: instret=%0d expected 0", sbus.instret_o);
        end
        sbus.valid_m_i = 1;
        tick();
        sbus.valid_m_i = 0;
        tick();
        exp_cnt = 4'd1;
        n_cmp++;
        if (sbus.instret_o !== exp_cnt) begin
            n_err++;
            $display("FAIL wrap_after: instret=%0d expected %0d", sbus.instret_o, exp_cnt);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 3) != 0, 1'($urandom), 5'($urandom),
                  ($urandom_range(0, 15) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3)),
                  $urandom, $urandom, $urandom, $urandom);
            bus.stall_w_i = ($urandom_range(0, 4) == 0);
            bus.flush_w_i = ($urandom_range(0, 9) == 0);
            bus.rs1_idx_d_i = ($urandom_range(0, 2) == 0) ? m_wrd : 5'($urandom);
            bus.rs2_idx_d_i = ($urandom_range(0, 2) == 0) ? m_wrd : 5'($urandom);
            #1;
            n_cmp++;
            if (bus.rs1_data_d_o !== m_read(bus.rs1_idx_d_i) || bus.rs2_data_d_o !== m_read(bus.rs2_idx_d_i)) begin
                n_err++;
                $display("FAIL rand_read[%0d]: rs1=%h rs2=%h expected %h/%h", n,
                         bus.rs1_data_d_o, bus.rs2_data_d_o,
                         m_read(bus.rs1_idx_d_i), m_read(bus.rs2_idx_d_i));
            end
            n_cmp++;
            if (bus.reg_write_en_w_o !== m_we() || (m_wv && (bus.result_w_o !== m_result()
                || bus.rd_idx_w_o !== m_wrd))) begin
                n_err++;
                $display("FAIL rand_w[%0d]: we=%b result=%h rd=%0d expected %b/%h/%0d", n,
                         bus.reg_write_en_w_o, bus.result_w_o, bus.rd_idx_w_o,
                         m_we(), m_result(), m_wrd);
            end
            n_cmp++;
            if (bus.instret_o !== m_instret || bus.illegal_src_o !== m_ill) begin
                n_err++;
                $display("FAIL rand_cnt[%0d]: instret=%0d illegal=%b expected %0d/%b", n,
                         bus.instret_o, bus.illegal_src_o, m_instret, m_ill);
            end
            tick();
        end
        bus.stall_w_i = 0; bus.flush_w_i = 0;
        idle();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_bypass();
        test_rd_zero();
        test_stall();
        test_flush();
        test_illegal();
        test_reset_midop();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
